// File: rtl/seg7_display_n.sv
// seg7_display_n: multiplexed 7-segment output register for the 8-bit CPU.
// Captures the bus when the CPU strobes the output register and shows the
// value as unsigned decimal, signed decimal or hex. A multi-cycle
// double-dabble converter fills a display buffer, and the buffer only
// changes in a single commit cycle, so the scanned digits never tear.
//
// Ports:
//   sys_clk   system clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   enable    output-register load enable from control logic
//   cpu_tick  one-cycle pulse marking the CPU clock rising edge
//   bus       CPU bus value to capture
//   mode      00 unsigned dec, 01 signed dec, 10 hex, 11 same as 00
//   busy      a conversion is in flight
//   segments  active-low {dp,g,f,e,d,c,b,a}; dp always off
//   digit     active-low one-hot digit select
module seg7_display_n #(
  parameter int DATA_WIDTH  = 8,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 16,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cpu_tick,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic [7:0]            segments,
  output logic [N_DIGITS-1:0]   digit
);

  // Decimal digits needed for DATA_WIDTH bits: ceil(DATA_WIDTH*log10(2)).
  localparam int BCD_N  = (DATA_WIDTH * 30103 + 99999) / 100000;
  localparam int ND_MAX = (BCD_N > N_DIGITS) ? BCD_N : N_DIGITS;
  localparam int SH_W   = 4 * BCD_N + DATA_WIDTH;
  localparam int STEP_W = $clog2(DATA_WIDTH);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned ND = N_DIGITS;

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'h0: seg_enc = 8'hC0;  4'h1: seg_enc = 8'hF9;
      4'h2: seg_enc = 8'hA4;  4'h3: seg_enc = 8'hB0;
      4'h4: seg_enc = 8'h99;  4'h5: seg_enc = 8'h92;
      4'h6: seg_enc = 8'h82;  4'h7: seg_enc = 8'hF8;
      4'h8: seg_enc = 8'h80;  4'h9: seg_enc = 8'h90;
      4'hA: seg_enc = 8'h88;  4'hB: seg_enc = 8'h83;
      4'hC: seg_enc = 8'hC6;  4'hD: seg_enc = 8'hA1;
      4'hE: seg_enc = 8'h86;  default: seg_enc = 8'h8E;
    endcase
  endfunction

  state_t                state_q, state_nx;
  logic [DATA_WIDTH-1:0] val_q, pend_val_q, start_val, start_mag;
  logic [1:0]            mode_q, pend_mode_q, start_mode, mode_in;
  logic                  pend_q, load, remode, start, start_neg;
  logic [SH_W-1:0]       shift_q, shift_nx;
  logic [STEP_W-1:0]     step_q;
  logic [7:0]            buf_q  [N_DIGITS];
  logic [7:0]            render [N_DIGITS];
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;

  assign load    = enable & cpu_tick;
  assign mode_in = (mode == 2'b11) ? 2'b00 : mode;
  // A mode change on an idle display reconverts the held value.
  assign remode  = (state_q == IDLE) && !load && (mode_in != mode_q);
  // Start a conversion from IDLE on a load or mode change, or straight from
  // COMMIT when a newer value is waiting, so intermediates are never shown.
  assign start   = ((state_q == IDLE) && (load || remode)) ||
                   ((state_q == COMMIT) && (load || pend_q));
  assign busy    = (state_q != IDLE);

  always_comb begin
    start_val  = val_q;
    start_mode = mode_in;
    if (load) begin
      start_val  = bus;
      start_mode = mode_in;
    end else if (state_q == COMMIT) begin
      start_val  = pend_val_q;
      start_mode = pend_mode_q;
    end
    start_neg = (start_mode == 2'b01) && start_val[DATA_WIDTH-1];
    start_mag = start_neg ? (~start_val + 1'b1) : start_val;
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
  always_comb begin
    logic [SH_W-1:0] tmp;
    tmp = shift_q;
    for (int unsigned i = 0; i < BCD_N; i++) begin
      if (tmp[DATA_WIDTH + 4*i +: 4] >= 4'd5)
        tmp[DATA_WIDTH + 4*i +: 4] = tmp[DATA_WIDTH + 4*i +: 4] + 4'd3;
    end
    shift_nx = tmp << 1;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (step_q == STEP_W'(DATA_WIDTH - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = start ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Digit rendering from the finished conversion, used only in COMMIT.
  always_comb begin
    logic [4*ND_MAX-1:0] bcd_pad, hex_pad;
    logic [3:0]          dig [ND_MAX];
    logic                neg, ovf;
    int unsigned         msd, minus_pos;
    bcd_pad = '0;
    hex_pad = '0;
    bcd_pad[4*BCD_N-1:0]    = shift_q[SH_W-1:DATA_WIDTH];
    hex_pad[DATA_WIDTH-1:0] = val_q;
    neg = (mode_q == 2'b01) && val_q[DATA_WIDTH-1];
    msd = 0;
    for (int unsigned i = 0; i < ND_MAX; i++) begin
      dig[i] = (mode_q == 2'b10) ? hex_pad[4*i +: 4] : bcd_pad[4*i +: 4];
      if (dig[i] != 4'd0) msd = i;
    end
    ovf       = (msd + 1 + (neg ? 1 : 0)) > ND;
    minus_pos = (BLANK_LZ != 0) ? msd + 1 : ND - 1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (ovf)                      render[i] = SEG_MINUS;
      else if (i <= msd)            render[i] = seg_enc(dig[i]);
      else if (neg && i == minus_pos) render[i] = SEG_MINUS;
      else if (BLANK_LZ != 0)       render[i] = SEG_BLANK;
      else                          render[i] = seg_enc(4'd0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      val_q       <= '0;
      mode_q      <= 2'b00;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      pend_mode_q <= 2'b00;
      shift_q     <= '0;
      step_q      <= '0;
      for (int unsigned i = 0; i < ND; i++)
        buf_q[i] <= (i == 0) ? seg_enc(4'd0) : SEG_BLANK;
    end else begin
      state_q <= state_nx;
      if (start) begin
        val_q   <= start_val;
        mode_q  <= start_mode;
        shift_q <= SH_W'(start_mag);
        step_q  <= '0;
      end else if (state_q == CONV) begin
        shift_q <= shift_nx;
        step_q  <= step_q + 1'b1;
      end
      // A load during COMMIT is consumed directly, superseding any pending one.
      if (state_q == CONV && load) begin
        pend_q      <= 1'b1;
        pend_val_q  <= bus;
        pend_mode_q <= mode_in;
      end else if (state_q == COMMIT) begin
        pend_q <= 1'b0;
      end
      if (state_q == COMMIT) begin
        for (int unsigned i = 0; i < ND; i++) buf_q[i] <= render[i];
      end
    end
  end

  // Scan: digit and segments are both registered from idx/buffer.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      digit    <= ~N_DIGITS'(1);
      segments <= seg_enc(4'd0);
    end else begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      digit    <= ~(N_DIGITS'(1) << idx_q);
      segments <= buf_q[idx_q];
    end
  end

endmodule
